hv_spatial_encoder: RTL and testbench
=====================================

// Module: hv_spatial_encoder
// PURPOSE
//   Stream consumer for per-channel hypervector fold slices (item-memory + projection slices).
//   Binds each beat (im XOR projm) and accumulates per-bit popcounts over a modality's channels.
//   Majority-thresholds each modality into one fold slice, then emits GSR/ECG/EEG slices per fold.
//   Sits between the HV generator and the cross-modality temporal/associative stages.
// PARAMETERS
//   FOLD_WIDTH      2000  bits per fold slice; must be a factor of the HV dimension
//   NUM_FOLDS       1     fold slices per feature vector (1 = unfolded)
//   NUM_FOLDS_WIDTH 1     width of fold index, >= ceil(log2(NUM_FOLDS)), min 1
//   GSR_CH          32    GSR channels per fold
//   ECG_CH          77    ECG channels per fold
//   EEG_CH          105   EEG channels per fold
//   CNT_WIDTH       7     popcount width, >= ceil(log2(max(GSR_CH,ECG_CH,EEG_CH)+1))
// PORTS
//   clk        in   1               clock, all logic on rising edge
//   rst        in   1               synchronous, active-high reset
//   din_valid  in   1               input beat valid
//   din_ready  out  1               input beat ready
//   im_in      in   FOLD_WIDTH      item-memory slice for current channel
//   projm_in   in   FOLD_WIDTH      projection slice for current channel (all-zero = feature 0)
//   dout_valid out  1               encoded fold result valid
//   dout_ready in   1               downstream accepts result
//   fold_idx   out  NUM_FOLDS_WIDTH fold number of current result, 0..NUM_FOLDS-1
//   last_fold  out  1               result is fold NUM_FOLDS-1 (end of feature vector)
//   gsr_hv     out  FOLD_WIDTH      GSR majority slice
//   ecg_hv     out  FOLD_WIDTH      ECG majority slice
//   eeg_hv     out  FOLD_WIDTH      EEG majority slice
// BEHAVIOUR
//   Beat order per vector: fold-major; per fold GSR_CH GSR beats, ECG_CH ECG beats, EEG_CH EEG beats.
//   Beat fires when din_valid && din_ready. No gaps required; din_valid may drop any cycle.
//   FSM: ACC_GSR -> ACC_ECG -> ACC_EEG -> EMIT -> ACC_GSR; din_ready = (state != EMIT).
//   ch_cnt counts fired beats in current modality; on beat with ch_cnt == N_mod-1: clear ch_cnt, next state.
//   Per bit b: bound[b] = im_in[b] ^ projm_in[b]; acc[b] loads bound[b] on ch_cnt==0, else acc[b]+bound[b].
//   Single shared acc bank (FOLD_WIDTH x CNT_WIDTH); no clear cycle needed (load on first beat).
//   Modality close (last beat fire): result[b] = ((acc[b]+bound[b]) * 2 > N_mod); ties -> 0.
//     Written into gsr_hv / ecg_hv / eeg_hv register respectively, same edge as the last beat.
//   EEG close -> EMIT: dout_valid = 1 the cycle after the last EEG beat fires (latency 1).
//   EMIT: outputs held stable until dout_valid && dout_ready; then fold_idx increments,
//     wrapping NUM_FOLDS-1 -> 0; state -> ACC_GSR; din_ready high the following cycle.
//   last_fold = (fold_idx == NUM_FOLDS-1), valid only with dout_valid.
//   No input accepted in EMIT (no pipelining of next fold over pending result).
//   Arithmetic: acc never exceeds N_mod, so no saturation logic; compare uses CNT_WIDTH+1 bits.
//   Reset (any state, incl. mid-fold/mid-EMIT): state=ACC_GSR, ch_cnt=0, fold_idx=0, dout_valid=0,
//     gsr_hv/ecg_hv/eeg_hv=0, acc don't-care; partial fold discarded; din_ready=1 first cycle after.
//   rst has priority over any concurrent fire in the same cycle.
//   N_mod of 1: single beat both loads and closes; result = bound.
// TESTING
//   FOLD_WIDTH=8, CH=3/3/3, 1 fold; all beats im=8'hFF, projm=8'h0F -> gsr/ecg/eeg_hv=8'hF0, last_fold=1.
//   CH=2/2/2, GSR beats bound 8'h01 then 8'h00 (tie) -> gsr_hv=8'h00; both 8'h01 -> 8'h01.
//   NUM_FOLDS=3, stream 3 folds -> fold_idx 0,1,2 with last_fold only on 2; next vector restarts at 0.
//   Hold dout_ready=0 for 5 cycles -> din_ready=0, outputs stable; release -> one handshake only.
//   Random din_valid gaps vs gap-free stream, same data -> identical results.
//   Assert rst after 4 ECG beats -> dout_valid=0, new full fold encodes correctly from fold 0.

Source files
------------

// File: rtl/hv_spatial_encoder.sv
// hv_spatial_encoder: binds item-memory and projection slices, then
// majority-encodes each modality (GSR, ECG, EEG) into one fold slice.
// Results are emitted once per fold through a valid/ready handshake.
module hv_spatial_encoder #(
  parameter int FOLD_WIDTH      = 2000,
  parameter int NUM_FOLDS       = 1,
  parameter int NUM_FOLDS_WIDTH = 1,
  parameter int GSR_CH          = 32,
  parameter int ECG_CH          = 77,
  parameter int EEG_CH          = 105,
  parameter int CNT_WIDTH       = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [FOLD_WIDTH-1:0]      im_in,
  input  logic [FOLD_WIDTH-1:0]      projm_in,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [NUM_FOLDS_WIDTH-1:0] fold_idx,
  output logic                       last_fold,
  output logic [FOLD_WIDTH-1:0]      gsr_hv,
  output logic [FOLD_WIDTH-1:0]      ecg_hv,
  output logic [FOLD_WIDTH-1:0]      eeg_hv
);

  typedef enum logic [1:0] {ACC_GSR, ACC_ECG, ACC_EEG, EMIT} state_t;

  localparam logic [CNT_WIDTH:0] GSR_N = (CNT_WIDTH+1)'(GSR_CH);
  localparam logic [CNT_WIDTH:0] ECG_N = (CNT_WIDTH+1)'(ECG_CH);
  localparam logic [CNT_WIDTH:0] EEG_N = (CNT_WIDTH+1)'(EEG_CH);
  localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_IDX = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  state_t                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       ch_cnt_q, ch_cnt_d;
  logic [CNT_WIDTH-1:0]       acc_q [FOLD_WIDTH];
  logic [CNT_WIDTH-1:0]       acc_d [FOLD_WIDTH];
  logic [NUM_FOLDS_WIDTH-1:0] fold_idx_q, fold_idx_d;
  logic [FOLD_WIDTH-1:0]      gsr_hv_q, gsr_hv_d;
  logic [FOLD_WIDTH-1:0]      ecg_hv_q, ecg_hv_d;
  logic [FOLD_WIDTH-1:0]      eeg_hv_q, eeg_hv_d;

  logic                       fire;
  logic                       mod_last;
  logic [CNT_WIDTH:0]         n_mod;
  logic [FOLD_WIDTH-1:0]      bound;
  logic [FOLD_WIDTH-1:0]      result;
  logic [CNT_WIDTH:0]         sum [FOLD_WIDTH];

  // State and control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC_GSR;
      ch_cnt_q   <= '0;
      fold_idx_q <= '0;
      gsr_hv_q   <= '0;
      ecg_hv_q   <= '0;
      eeg_hv_q   <= '0;
    end else begin
      state_q    <= state_d;
      ch_cnt_q   <= ch_cnt_d;
      fold_idx_q <= fold_idx_d;
      gsr_hv_q   <= gsr_hv_d;
      ecg_hv_q   <= ecg_hv_d;
      eeg_hv_q   <= eeg_hv_d;
    end
  end

  // Popcount bank; contents are reloaded on the first beat of each modality
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC_GSR: if (fire && mod_last) state_d = ACC_ECG;
      ACC_ECG: if (fire && mod_last) state_d = ACC_EEG;
      ACC_EEG: if (fire && mod_last) state_d = EMIT;
      EMIT:    if (dout_ready)       state_d = ACC_GSR;
      default:                       state_d = ACC_GSR;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    din_ready  = (state_q != EMIT);
    dout_valid = (state_q == EMIT);
  end

  // Bind, accumulate and majority-threshold the current beat
  always_comb begin
    fire  = din_valid && din_ready;
    bound = im_in ^ projm_in;
    case (state_q)
      ACC_ECG: n_mod = ECG_N;
      ACC_EEG: n_mod = EEG_N;
      default: n_mod = GSR_N;
    endcase
    mod_last = ({1'b0, ch_cnt_q} == n_mod - 1'b1);
    for (int unsigned b = 0; b < FOLD_WIDTH; b++) begin
      sum[b]    = ((ch_cnt_q == '0) ? '0 : {1'b0, acc_q[b]})
                  + {{CNT_WIDTH{1'b0}}, bound[b]};
      // 2*sum > N, strict so ties resolve to 0
      result[b] = ({sum[b], 1'b0} > {1'b0, n_mod});
      acc_d[b]  = fire ? sum[b][CNT_WIDTH-1:0] : acc_q[b];
    end
  end

  // Channel counter, fold index and result registers
  always_comb begin
    ch_cnt_d   = ch_cnt_q;
    fold_idx_d = fold_idx_q;
    gsr_hv_d   = gsr_hv_q;
    ecg_hv_d   = ecg_hv_q;
    eeg_hv_d   = eeg_hv_q;
    if (fire) begin
      ch_cnt_d = mod_last ? '0 : ch_cnt_q + 1'b1;
      if (mod_last) begin
        case (state_q)
          ACC_GSR: gsr_hv_d = result;
          ACC_ECG: ecg_hv_d = result;
          ACC_EEG: eeg_hv_d = result;
          default: ;
        endcase
      end
    end
    if (state_q == EMIT && dout_ready) begin
      fold_idx_d = (fold_idx_q == LAST_IDX) ? '0 : fold_idx_q + 1'b1;
    end
  end

  assign fold_idx  = fold_idx_q;
  assign last_fold = (fold_idx_q == LAST_IDX);
  assign gsr_hv    = gsr_hv_q;
  assign ecg_hv    = ecg_hv_q;
  assign eeg_hv    = eeg_hv_q;

endmodule

// File: tb/tb_hv_spatial_encoder.sv
// Self-checking bench for hv_spatial_encoder: small configuration with an
// even modality (tie case), an odd modality and a single-channel modality.
module tb_hv_spatial_encoder;

  localparam int W  = 8;
  localparam int NF = 3;
  localparam int NFW = 2;
  localparam int G  = 2;
  localparam int E  = 3;
  localparam int EE = 1;
  localparam int T  = G + E + EE;

  logic           clk = 1'b0;
  logic           rst;
  logic           din_valid;
  logic           din_ready;
  logic [W-1:0]   im_in;
  logic [W-1:0]   projm_in;
  logic           dout_valid;
  logic           dout_ready;
  logic [NFW-1:0] fold_idx;
  logic           last_fold;
  logic [W-1:0]   gsr_hv;
  logic [W-1:0]   ecg_hv;
  logic [W-1:0]   eeg_hv;

  int vectors = 0;
  int miscompares = 0;
  int exp_fold = 0;

  logic [W-1:0] cur_im [T];
  logic [W-1:0] cur_pm [T];

  always #5 clk = ~clk;

  hv_spatial_encoder #(
    .FOLD_WIDTH(W), .NUM_FOLDS(NF), .NUM_FOLDS_WIDTH(NFW),
    .GSR_CH(G), .ECG_CH(E), .EEG_CH(EE), .CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready),
    .im_in(im_in), .projm_in(projm_in),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .fold_idx(fold_idx), .last_fold(last_fold),
    .gsr_hv(gsr_hv), .ecg_hv(ecg_hv), .eeg_hv(eeg_hv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count ones per bit position over a modality's bound slices
  function automatic logic [W-1:0] majority(input int start, input int n);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < n; k++) begin
        logic [W-1:0] bv;
        bv = cur_im[start+k] ^ cur_pm[start+k];
        ones += int'(bv[b]);
      end
      r[b] = (2 * ones > n);
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < T; i++) begin
      cur_im[i] = W'($urandom);
      cur_pm[i] = W'($urandom);
    end
  endtask

  task automatic fill_const(input logic [W-1:0] im_v, input logic [W-1:0] pm_v);
    for (int i = 0; i < T; i++) begin
      cur_im[i] = im_v;
      cur_pm[i] = pm_v;
    end
  endtask

  // Called at a negedge; returns at the negedge after the last beat fires
  task automatic send_fold(input bit gaps);
    for (int i = 0; i < T; i++) begin
      if (gaps) begin
        din_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      chk("din_ready_acc", din_ready, 1'b1);
      din_valid = 1'b1;
      im_in     = cur_im[i];
      projm_in  = cur_pm[i];
      @(negedge clk);
    end
    din_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_dout_valid"}, dout_valid, 1'b1);
    chk({tag, "_din_ready"}, din_ready, 1'b0);
    chk({tag, "_fold_idx"}, fold_idx, exp_fold);
    chk({tag, "_last_fold"}, last_fold, (exp_fold == NF - 1));
    chk({tag, "_gsr"}, gsr_hv, majority(0, G));
    chk({tag, "_ecg"}, ecg_hv, majority(G, E));
    chk({tag, "_eeg"}, eeg_hv, majority(G + E, EE));
  endtask

  // Result check, optional back-pressure with junk input offered, then handshake
  task automatic finish_fold(input int hold);
    check_outputs("emit");
    for (int h = 0; h < hold; h++) begin
      dout_ready = 1'b0;
      din_valid  = 1'b1;
      im_in      = W'($urandom);
      projm_in   = W'($urandom);
      @(negedge clk);
      check_outputs("hold");
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    exp_fold   = (exp_fold + 1) % NF;
    chk("post_hs_dout_valid", dout_valid, 1'b0);
    chk("post_hs_din_ready", din_ready, 1'b1);
    chk("post_hs_fold_idx", fold_idx, exp_fold);
  endtask

  task automatic do_reset();
    din_valid = 1'b1;
    im_in     = W'($urandom);
    projm_in  = W'($urandom);
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
    exp_fold  = 0;
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_din_ready", din_ready, 1'b1);
    chk("rst_fold_idx", fold_idx, 0);
    chk("rst_gsr", gsr_hv, 0);
    chk("rst_ecg", ecg_hv, 0);
    chk("rst_eeg", eeg_hv, 0);
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    im_in = '0; projm_in = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // All beats bind to F0 -> every modality F0, fold 0
    fill_const(8'hFF, 8'h0F);
    send_fold(1'b0);
    chk("const_gsr", gsr_hv, 8'hF0);
    chk("const_eeg", eeg_hv, 8'hF0);
    finish_fold(0);

    // GSR tie (01 then 00) -> 00; single EEG beat passes bound through
    fill_random();
    cur_im[0] = 8'h01; cur_pm[0] = 8'h00;
    cur_im[1] = 8'h00; cur_pm[1] = 8'h00;
    cur_im[5] = 8'hA5; cur_pm[5] = 8'h00;
    send_fold(1'b0);
    chk("tie_gsr", gsr_hv, 8'h00);
    chk("single_eeg", eeg_hv, 8'hA5);
    finish_fold(0);

    // Both GSR beats 01 -> 01; this is the last fold of the vector
    fill_random();
    cur_im[0] = 8'h01; cur_pm[0] = 8'h00;
    cur_im[1] = 8'h03; cur_pm[1] = 8'h02;
    send_fold(1'b0);
    chk("agree_gsr", gsr_hv, 8'h01);
    chk("last_fold_2", last_fold, 1'b1);
    finish_fold(0);

    // Next vector restarts at fold 0 (checked inside), with back-pressure
    fill_random();
    send_fold(1'b0);
    finish_fold(5);

    // Same random data gap-free and with gaps
    for (int r = 0; r < 6; r++) begin
      fill_random();
      send_fold(1'b0);
      finish_fold(r % 2);
      send_fold(1'b1);
      finish_fold(0);
    end

    // Reset mid-ECG, then a full fold from fold 0
    fill_random();
    for (int i = 0; i < G + 2; i++) begin
      din_valid = 1'b1; im_in = cur_im[i]; projm_in = cur_pm[i];
      @(negedge clk);
    end
    do_reset();
    fill_random();
    send_fold(1'b1);
    finish_fold(0);

    // Reset while a result is pending
    fill_random();
    send_fold(1'b0);
    check_outputs("pre_rst");
    do_reset();
    fill_random();
    send_fold(1'b0);
    finish_fold(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
